// File: rtl/leg_pkg.sv
// Shared definitions for the fetch/execute pair.
//   INST_WIDTH       instruction width
//   fetch_state_t    fetch FSM states
//   OPC_* / OPA_*    opcode / operand field positions, shared with execute
//   opcode()         helper to pull the opcode field out of an instruction
package leg_pkg;
  localparam int INST_WIDTH = 16;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int OPA_MSB = 11;
  localparam int OPA_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } fetch_state_t;

  function automatic logic [OPC_MSB-OPC_LSB:0] opcode(input logic [INST_WIDTH-1:0] inst);
    return inst[OPC_MSB:OPC_LSB];
  endfunction
endpackage

// File: rtl/inst_fifo.sv
// Prefetch FIFO between the fetch FSM and execute.
//   clk, rst_n     clock, async active-low reset
//   push, data     write one word
//   pop            consume head (ignored when empty)
//   flush          drop all entries (wins over push/pop)
//   count          current occupancy
//   head           oldest entry, driven straight from storage (no bypass)
module inst_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  input  logic             pop,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Storage is reset so the head reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: issues single-word requests to a variable-latency
// instruction memory, queues responses in a prefetch FIFO and hands them to
// execute over a ready/ack handshake.
//   i_clk, i_rst_n              clock, async active-low reset
//   i_en                        allow new memory requests
//   o_mem_req, o_mem_addr       one-cycle request pulse + word address
//   i_mem_valid, i_mem_data     one-cycle response
//   o_inst, o_inst_ready        FIFO head / non-empty, to execute
//   i_inst_ack                  execute consumed the head
//   o_pc                        next address to be requested
//   i_redirect, i_redirect_pc   only with FETCH_REDIRECT_EN: flush + new PC
// Optional feature macro: FETCH_REDIRECT_EN
module inst_fetch
  import leg_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter int          INST_WIDTH = leg_pkg::INST_WIDTH,
  parameter int          FIFO_DEPTH = 4,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_valid,
  input  logic [INST_WIDTH-1:0] i_mem_data,
  output logic [INST_WIDTH-1:0] o_inst,
  output logic                  o_inst_ready,
  input  logic                  i_inst_ack,
`ifdef FETCH_REDIRECT_EN
  input  logic                  i_redirect,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
`endif
  output logic [ADDR_WIDTH-1:0] o_pc
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(RESET_PC);

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  mem_req;
  logic                  kill;      // outstanding response belongs to a dead stream
  logic [CW-1:0]         count, cnt_nxt;
  logic                  push, pop, credit, go;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;

`ifdef FETCH_REDIRECT_EN
  assign redirect    = i_redirect;
  assign redirect_pc = i_redirect_pc;
`else
  assign redirect    = 1'b0;
  assign redirect_pc = RST_PC;
`endif

  // Redirect dominates: it flushes, so neither the response nor the ack lands.
  assign push = (state == S_WAIT) && i_mem_valid && !kill && !redirect;
  assign pop  = i_inst_ack && (count != '0) && !redirect;

  // Occupancy after this edge. A request is only launched when that leaves
  // room for its response, so entries + outstanding never exceed FIFO_DEPTH.
  assign cnt_nxt = redirect ? '0 : count + CW'(push) - CW'(pop);
  assign credit  = cnt_nxt < CW'(FIFO_DEPTH);
  assign go      = i_en && credit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      pc      <= RST_PC;
      mem_req <= 1'b0;
      kill    <= 1'b0;
    end else begin
      mem_req <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (redirect) pc <= redirect_pc;
          if (go) begin
            state   <= S_REQ;
            mem_req <= 1'b1;
          end
        end
        S_REQ: begin
          state <= S_WAIT;
          if (redirect) begin
            pc   <= redirect_pc;
            kill <= 1'b1;            // request already on the bus: drop its reply
          end else begin
            pc <= pc + ADDR_WIDTH'(1); // wraps silently
          end
        end
        S_WAIT: begin
          if (redirect) pc <= redirect_pc;
          if (i_mem_valid) begin
            kill <= 1'b0;
            if (go) begin
              state   <= S_REQ;
              mem_req <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end else if (redirect) begin
            kill <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  inst_fifo #(.WIDTH(INST_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push),
    .data  (i_mem_data),
    .pop   (pop),
    .flush (redirect),
    .count (count),
    .head  (o_inst)
  );

  assign o_mem_req    = mem_req;
  assign o_mem_addr   = pc;
  assign o_pc         = pc;
  assign o_inst_ready = (count != '0);
endmodule
